uart_row_loader: RTL and testbench
==================================

Name: uart_row_loader

Overview:
- Consumes the byte stream from the controller's UART receiver and assembles row-load commands into framebuffer write cycles.
- Sits between the UART RX byte deframer, which delivers 8-bit bytes with a one-cycle valid strobe, and the framebuffer RAM write port.
- Parses the header, sequences payload bytes into RAM addresses, checks an XOR checksum, and aborts stalled frames on an inter-byte timeout.

Parameters:
- ROW_BYTES, 256, number of payload bytes per row; power of two.
- ROW_BYTES_WIDTH, 8, log2(ROW_BYTES).
- ROWS, 16, number of valid row addresses; row byte must be < ROWS.
- ROW_ADDR_WIDTH, 4, log2(ROWS).
- CMD_LOAD, 8'h4C, header byte ('L') that opens a frame.
- TIMEOUT_TICKS, 20'd10000, clk_in cycles allowed between bytes inside a frame.
- TIMEOUT_WIDTH, 5'd20, counter width for TIMEOUT_TICKS.

Ports:
- clk_in  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- rx_data  input  8  received byte; valid only while rx_valid=1.
- rx_valid  input  1  one-cycle strobe per received byte.
- wr_addr  output  ROW_ADDR_WIDTH+ROW_BYTES_WIDTH  framebuffer address {row, byte_index}.
- wr_data  output  8  framebuffer write data.
- wr_en  output  1  framebuffer write strobe, one cycle per byte.
- row_done  output  1  one-cycle pulse when a frame completes.
- row_addr_out  output  ROW_ADDR_WIDTH  row of the last completed frame; held until the next completion.
- csum_ok  output  1  checksum result of the last completed frame; held.
- frame_error  output  1  one-cycle pulse on timeout abort or bad row address.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, all outputs 0, byte index 0, checksum 0, timeout counter 0.
- States: IDLE, ROW, DATA, DISCARD, CSUM.
- IDLE:
  - rx_valid with rx_data==CMD_LOAD -> ROW; checksum accumulator := 0.
  - Any other byte is ignored.
- ROW, on rx_valid:
  - If rx_data < ROWS: latch the row, index := 0, -> DATA.
  - Else: pulse frame_error, index := 0, -> DISCARD.
  - The row byte is not included in the checksum.
- DATA, on rx_valid:
  - The next cycle drives wr_en=1, wr_addr={row,index}, wr_data=rx_data (latency 1 cycle).
  - checksum ^= rx_data; index increments.
  - On byte index ROW_BYTES-1 -> CSUM.
  - index wraps to 0 only at the transition to CSUM.
- DISCARD: counts ROW_BYTES bytes with wr_en held 0, then -> CSUM. This resynchronises the stream without corrupting RAM.
- CSUM, on rx_valid:
  - Next cycle: row_done=1, csum_ok=(checksum==rx_data), row_addr_out=row; -> IDLE.
  - From DISCARD: csum_ok=0, row_done=0 (frame_error has already fired).
- Timeout:
  - The counter runs in every non-IDLE state, clears on each rx_valid, and holds at 0 in IDLE.
  - When it reaches TIMEOUT_TICKS-1 with no rx_valid: pulse frame_error, -> IDLE. No row_done.
  - rx_valid in the same cycle the terminal count is reached wins: the byte is processed and no timeout occurs.
- RAM writes already issued are not rolled back on checksum failure or timeout. The consumer gates display swap on csum_ok.
- wr_en, row_done and frame_error are registered single-cycle pulses.
- Back-to-back bytes (rx_valid on consecutive cycles) are accepted in every state.
- Reset asserted mid-frame: immediate return to IDLE with outputs cleared. Any in-flight wr_en is dropped.

Decomposition:
- Shared package (display_pkg):
  - loader_state_t enum.
  - CMD_LOAD constant.
  - ROW_BYTES / ROWS defaults.
  - Framebuffer address-width localparams shared with the framebuffer and the row scanner.
- Sub-module timeout_counter (load-clear, terminal-count pulse, TIMEOUT_WIDTH wide); it is reusable by the debug command path.

Test Plan:
- Nominal frame: 'L', row 8'h03, payload bytes i=0..255 (value i), checksum 8'h00 -> 256 writes at addresses 0x300..0x3FF with data=i; row_done pulse; row_addr_out=3; csum_ok=1.
- Bad checksum: same frame with trailing 8'h5A -> 256 writes occur; row_done=1; csum_ok=0.
- Bad row: 'L', row 8'h14 (20 >= ROWS) -> frame_error pulse one cycle after the row byte; the next 257 bytes produce no wr_en and no row_done; a following valid frame loads normally.
- Timeout: 'L', row 2, 10 payload bytes, then idle for TIMEOUT_TICKS cycles -> exactly 10 writes; frame_error at the terminal count; busy=0 afterwards; a subsequent 'L' frame completes.
- Noise and back-to-back bytes: bytes 8'h00, 8'h41 in IDLE ignored; then a full frame with rx_valid on every cycle -> wr_en high on 256 consecutive cycles with correct addresses.
- Reset mid-frame: drop reset for 1 cycle after byte 100 -> all outputs 0 immediately; then 'L', row 1 plus a full payload loads row 1 from index 0.

Source files
------------

// File: rtl/display_pkg.sv
// Shared framebuffer geometry, row-loader command byte and loader state encoding.
// Used by the UART row loader, the framebuffer and the row scanner.
package display_pkg;

  localparam int FB_ROW_BYTES       = 256;
  localparam int FB_ROW_BYTES_WIDTH = 8;
  localparam int FB_ROWS            = 16;
  localparam int FB_ROW_ADDR_WIDTH  = 4;
  localparam int FB_ADDR_WIDTH      = FB_ROW_ADDR_WIDTH + FB_ROW_BYTES_WIDTH;

  localparam logic [7:0] LOADER_CMD_LOAD      = 8'h4C;
  localparam int         LOADER_TIMEOUT_TICKS = 10000;
  localparam int         LOADER_TIMEOUT_WIDTH = 20;

  typedef enum logic [2:0] {
    LD_IDLE,
    LD_ROW,
    LD_DATA,
    LD_DISCARD,
    LD_CSUM
  } loader_state_t;

endpackage

// File: rtl/uart_row_loader_timeout_counter.sv
// Inactivity counter: clears on 'clear' or when not running; tc is high for one cycle at TICKS-1.
// Latency: tc is combinational from the count register; no backpressure.
module timeout_counter #(
  parameter int WIDTH = 20,
  parameter int TICKS = 10000
) (
  input  logic clk_in,
  input  logic reset,
  input  logic run,
  input  logic clear,
  output logic tc
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(TICKS - 1);

  logic [WIDTH-1:0] count_q, count_d;

  // A clear in the terminal cycle suppresses the expiry.
  assign tc = run && !clear && (count_q == LAST);

  always_comb begin
    count_d = count_q + WIDTH'(1);
    if (!run || clear || tc) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_row_loader.sv
// Parses 'L', row, ROW_BYTES payload, XOR checksum from UART bytes into framebuffer writes.
// Latency: one cycle from rx_valid to wr_en/row_done; no backpressure, a byte is accepted every cycle.
module uart_row_loader
  import display_pkg::*;
#(
  parameter int         ROW_BYTES       = FB_ROW_BYTES,
  parameter int         ROW_BYTES_WIDTH = FB_ROW_BYTES_WIDTH,
  parameter int         ROWS            = FB_ROWS,
  parameter int         ROW_ADDR_WIDTH  = FB_ROW_ADDR_WIDTH,
  parameter logic [7:0] CMD_LOAD        = LOADER_CMD_LOAD,
  parameter int         TIMEOUT_TICKS   = LOADER_TIMEOUT_TICKS,
  parameter int         TIMEOUT_WIDTH   = LOADER_TIMEOUT_WIDTH
) (
  input  logic                                      clk_in,
  input  logic                                      reset,
  input  logic [7:0]                                rx_data,
  input  logic                                      rx_valid,
  output logic [ROW_ADDR_WIDTH+ROW_BYTES_WIDTH-1:0] wr_addr,
  output logic [7:0]                                wr_data,
  output logic                                      wr_en,
  output logic                                      row_done,
  output logic [ROW_ADDR_WIDTH-1:0]                 row_addr_out,
  output logic                                      csum_ok,
  output logic                                      frame_error,
  output logic                                      busy
);

  localparam int                         AW        = ROW_ADDR_WIDTH + ROW_BYTES_WIDTH;
  localparam logic [ROW_BYTES_WIDTH-1:0] IDX_LAST  = ROW_BYTES_WIDTH'(ROW_BYTES - 1);
  localparam logic [8:0]                 ROW_LIMIT = 9'(ROWS);

  loader_state_t             state_q, state_d;
  logic [ROW_ADDR_WIDTH-1:0] row_q, row_d;
  logic [ROW_BYTES_WIDTH-1:0] idx_q, idx_d;
  logic [7:0]                csum_q, csum_d;
  logic                      discard_q, discard_d;
  logic                      wr_en_q, wr_en_d;
  logic [AW-1:0]             wr_addr_q, wr_addr_d;
  logic [7:0]                wr_data_q, wr_data_d;
  logic                      row_done_q, row_done_d;
  logic [ROW_ADDR_WIDTH-1:0] row_addr_out_q, row_addr_out_d;
  logic                      csum_ok_q, csum_ok_d;
  logic                      frame_error_q, frame_error_d;
  logic                      busy_q, busy_d;

  logic tmo_run;
  logic tmo_tc;

  assign tmo_run = (state_q != LD_IDLE);

  timeout_counter #(
    .WIDTH (TIMEOUT_WIDTH),
    .TICKS (TIMEOUT_TICKS)
  ) u_timeout (
    .clk_in (clk_in),
    .reset  (reset),
    .run    (tmo_run),
    .clear  (rx_valid),
    .tc     (tmo_tc)
  );

  always_comb begin
    state_d        = state_q;
    row_d          = row_q;
    idx_d          = idx_q;
    csum_d         = csum_q;
    discard_d      = discard_q;
    wr_en_d        = 1'b0;
    wr_addr_d      = wr_addr_q;
    wr_data_d      = wr_data_q;
    row_done_d     = 1'b0;
    row_addr_out_d = row_addr_out_q;
    csum_ok_d      = csum_ok_q;
    frame_error_d  = 1'b0;

    case (state_q)
      LD_IDLE: begin
        if (rx_valid && (rx_data == CMD_LOAD)) begin
          csum_d  = 8'h00;
          state_d = LD_ROW;
        end
      end
      LD_ROW: begin
        if (rx_valid) begin
          idx_d = '0;
          if ({1'b0, rx_data} < ROW_LIMIT) begin
            row_d     = rx_data[ROW_ADDR_WIDTH-1:0];
            discard_d = 1'b0;
            state_d   = LD_DATA;
          end else begin
            frame_error_d = 1'b1;
            discard_d     = 1'b1;
            state_d       = LD_DISCARD;
          end
        end
      end
      LD_DATA: begin
        if (rx_valid) begin
          wr_en_d   = 1'b1;
          wr_addr_d = {row_q, idx_q};
          wr_data_d = rx_data;
          csum_d    = csum_q ^ rx_data;
          idx_d     = idx_q + ROW_BYTES_WIDTH'(1);
          if (idx_q == IDX_LAST) begin
            state_d = LD_CSUM;
          end
        end
      end
      LD_DISCARD: begin
        // Swallow a full payload so the next 'L' lands on a real frame boundary.
        if (rx_valid) begin
          idx_d = idx_q + ROW_BYTES_WIDTH'(1);
          if (idx_q == IDX_LAST) begin
            state_d = LD_CSUM;
          end
        end
      end
      LD_CSUM: begin
        if (rx_valid) begin
          state_d = LD_IDLE;
          if (discard_q) begin
            csum_ok_d = 1'b0;
          end else begin
            row_done_d     = 1'b1;
            csum_ok_d      = (csum_q == rx_data);
            row_addr_out_d = row_q;
          end
        end
      end
      default: begin
        state_d = LD_IDLE;
      end
    endcase

    if (tmo_tc) begin
      frame_error_d = 1'b1;
      state_d       = LD_IDLE;
    end

    busy_d = (state_d != LD_IDLE);
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_q        <= LD_IDLE;
      row_q          <= '0;
      idx_q          <= '0;
      csum_q         <= 8'h00;
      discard_q      <= 1'b0;
      wr_en_q        <= 1'b0;
      wr_addr_q      <= '0;
      wr_data_q      <= 8'h00;
      row_done_q     <= 1'b0;
      row_addr_out_q <= '0;
      csum_ok_q      <= 1'b0;
      frame_error_q  <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      row_q          <= row_d;
      idx_q          <= idx_d;
      csum_q         <= csum_d;
      discard_q      <= discard_d;
      wr_en_q        <= wr_en_d;
      wr_addr_q      <= wr_addr_d;
      wr_data_q      <= wr_data_d;
      row_done_q     <= row_done_d;
      row_addr_out_q <= row_addr_out_d;
      csum_ok_q      <= csum_ok_d;
      frame_error_q  <= frame_error_d;
      busy_q         <= busy_d;
    end
  end

  assign wr_en        = wr_en_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign row_done     = row_done_q;
  assign row_addr_out = row_addr_out_q;
  assign csum_ok      = csum_ok_q;
  assign frame_error  = frame_error_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_uart_row_loader.sv
// Directed bench for uart_row_loader: nominal, bad checksum, bad row, timeout, back-to-back, reset.
module tb_uart_row_loader;

  logic        clk_in = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [11:0] wr_addr;
  logic [7:0]  wr_data;
  logic        wr_en;
  logic        row_done;
  logic [3:0]  row_addr_out;
  logic        csum_ok;
  logic        frame_error;
  logic        busy;

  int n_assert = 0;
  int n_fail   = 0;

  int          cyc = 0;
  logic [11:0] q_addr[$];
  logic [7:0]  q_data[$];
  int          q_cyc[$];
  int          rd_cnt = 0;
  int          fe_cnt = 0;

  always #5 clk_in = ~clk_in;

  uart_row_loader dut (
    .clk_in       (clk_in),
    .reset        (reset),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_en        (wr_en),
    .row_done     (row_done),
    .row_addr_out (row_addr_out),
    .csum_ok      (csum_ok),
    .frame_error  (frame_error),
    .busy         (busy)
  );

  // Write/pulse recorder, sampled on the falling edge.
  always @(negedge clk_in) begin
    cyc++;
    if (wr_en === 1'b1) begin
      q_addr.push_back(wr_addr);
      q_data.push_back(wr_data);
      q_cyc.push_back(cyc);
    end
    if (row_done === 1'b1) rd_cnt++;
    if (frame_error === 1'b1) fe_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    q_addr.delete();
    q_data.delete();
    q_cyc.delete();
    rd_cnt = 0;
    fe_cnt = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk_in); #1;
    rx_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk_in); #1;
    end
  endtask

  task automatic send_payload(input logic [7:0] key, input int gap, input int from, input int upto);
    for (int i = from; i <= upto; i++) begin
      send_byte(8'(i) ^ key, gap);
    end
  endtask

  task automatic check_writes(input logic [3:0] row, input logic [7:0] key, input int n,
                              input bit consec);
    chk("wr_count", 32'(q_addr.size()), 32'(n));
    for (int i = 0; i < n && i < q_addr.size(); i++) begin
      logic [7:0] idx;
      idx = 8'(i);
      chk("wr_addr", 32'(q_addr[i]), 32'({row, idx}));
      chk("wr_data", 32'(q_data[i]), 32'(idx ^ key));
      if (consec && i > 0) chk("wr_b2b_gap", 32'(q_cyc[i] - q_cyc[i-1]), 32'd1);
    end
  endtask

  initial begin
    reset    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (2) @(posedge clk_in);
    #1;
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    chk("rst_row_done", 32'(row_done), 32'd0);
    chk("rst_row_addr_out", 32'(row_addr_out), 32'd0);
    chk("rst_csum_ok", 32'(csum_ok), 32'd0);
    chk("rst_frame_error", 32'(frame_error), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b1;
    @(posedge clk_in); #1;
    chk("idle_busy", 32'(busy), 32'd0);

    // Nominal frame, row 3, payload i, checksum 0x00.
    clear_stats();
    send_byte(8'h4C, 1);
    chk("nom_busy_after_L", 32'(busy), 32'd1);
    send_byte(8'h03, 1);
    send_payload(8'h00, 1, 0, 255);
    send_byte(8'h00, 0);
    chk("nom_row_done", 32'(row_done), 32'd1);
    chk("nom_csum_ok", 32'(csum_ok), 32'd1);
    chk("nom_row_addr_out", 32'(row_addr_out), 32'd3);
    chk("nom_busy_end", 32'(busy), 32'd0);
    @(posedge clk_in); #1;
    chk("nom_row_done_pulse", 32'(row_done), 32'd0);
    chk("nom_row_addr_hold", 32'(row_addr_out), 32'd3);
    chk("nom_rd_cnt", 32'(rd_cnt), 32'd1);
    check_writes(4'h3, 8'h00, 256, 1'b0);

    // Bad row 0x14: error one cycle after the row byte, next 257 bytes swallowed.
    clear_stats();
    send_byte(8'h4C, 1);
    send_byte(8'h14, 0);
    chk("badrow_frame_error", 32'(frame_error), 32'd1);
    chk("badrow_busy", 32'(busy), 32'd1);
    @(posedge clk_in); #1;
    chk("badrow_fe_pulse", 32'(frame_error), 32'd0);
    send_payload(8'h00, 1, 0, 255);
    send_byte(8'h00, 0);
    chk("badrow_row_done", 32'(row_done), 32'd0);
    chk("badrow_csum_ok", 32'(csum_ok), 32'd0);
    chk("badrow_busy_end", 32'(busy), 32'd0);
    chk("badrow_row_addr_hold", 32'(row_addr_out), 32'd3);
    @(posedge clk_in); #1;
    chk("badrow_rd_cnt", 32'(rd_cnt), 32'd0);
    chk("badrow_fe_cnt", 32'(fe_cnt), 32'd1);
    check_writes(4'h3, 8'h00, 0, 1'b0);

    // Following frame loads normally but carries a bad checksum.
    clear_stats();
    send_byte(8'h4C, 1);
    send_byte(8'h03, 1);
    send_payload(8'h00, 1, 0, 255);
    send_byte(8'h5A, 0);
    chk("badcs_row_done", 32'(row_done), 32'd1);
    chk("badcs_csum_ok", 32'(csum_ok), 32'd0);
    chk("badcs_row_addr_out", 32'(row_addr_out), 32'd3);
    @(posedge clk_in); #1;
    check_writes(4'h3, 8'h00, 256, 1'b0);

    // Timeout after 10 payload bytes of row 2.
    clear_stats();
    send_byte(8'h4C, 1);
    send_byte(8'h02, 1);
    send_payload(8'h00, 1, 0, 8);
    send_byte(8'h09, 0);
    repeat (9999) @(posedge clk_in);
    #1;
    chk("tmo_fe_before_tc", 32'(frame_error), 32'd0);
    chk("tmo_busy_before_tc", 32'(busy), 32'd1);
    @(posedge clk_in); #1;
    chk("tmo_frame_error", 32'(frame_error), 32'd1);
    chk("tmo_busy_after", 32'(busy), 32'd0);
    @(posedge clk_in); #1;
    chk("tmo_fe_pulse", 32'(frame_error), 32'd0);
    chk("tmo_fe_cnt", 32'(fe_cnt), 32'd1);
    chk("tmo_rd_cnt", 32'(rd_cnt), 32'd0);
    check_writes(4'h2, 8'h00, 10, 1'b0);

    // A byte arriving exactly at the terminal count wins over the timeout.
    clear_stats();
    send_byte(8'h4C, 1);
    send_byte(8'h02, 0);
    repeat (9999) @(posedge clk_in);
    #1;
    send_byte(8'h00, 0);
    chk("race_wr_en", 32'(wr_en), 32'd1);
    chk("race_frame_error", 32'(frame_error), 32'd0);
    chk("race_busy", 32'(busy), 32'd1);
    send_payload(8'h00, 1, 1, 255);
    send_byte(8'h00, 0);
    chk("race_row_done", 32'(row_done), 32'd1);
    chk("race_csum_ok", 32'(csum_ok), 32'd1);
    chk("race_row_addr_out", 32'(row_addr_out), 32'd2);
    @(posedge clk_in); #1;
    chk("race_fe_cnt", 32'(fe_cnt), 32'd0);
    check_writes(4'h2, 8'h00, 256, 1'b0);

    // Noise in IDLE, then a fully back-to-back frame on the last valid row.
    clear_stats();
    send_byte(8'h00, 0);
    send_byte(8'h41, 0);
    @(posedge clk_in); #1;
    chk("noise_busy", 32'(busy), 32'd0);
    send_byte(8'h4C, 0);
    send_byte(8'h0F, 0);
    send_payload(8'h3C, 0, 0, 255);
    send_byte(8'h00, 0);
    chk("b2b_row_done", 32'(row_done), 32'd1);
    chk("b2b_csum_ok", 32'(csum_ok), 32'd1);
    chk("b2b_row_addr_out", 32'(row_addr_out), 32'd15);
    @(posedge clk_in); #1;
    check_writes(4'hF, 8'h3C, 256, 1'b1);

    // Reset mid-frame right after payload byte 100.
    send_byte(8'h4C, 1);
    send_byte(8'h01, 1);
    send_payload(8'h55, 1, 0, 99);
    send_byte(8'd100 ^ 8'h55, 0);
    chk("mid_wr_en_inflight", 32'(wr_en), 32'd1);
    reset = 1'b0;
    #1;
    chk("mid_rst_wr_en", 32'(wr_en), 32'd0);
    chk("mid_rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("mid_rst_wr_data", 32'(wr_data), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_row_addr_out", 32'(row_addr_out), 32'd0);
    chk("mid_rst_csum_ok", 32'(csum_ok), 32'd0);
    @(posedge clk_in); #1;
    reset = 1'b1;
    clear_stats();
    @(posedge clk_in); #1;
    send_byte(8'h4C, 1);
    send_byte(8'h01, 1);
    send_payload(8'h55, 1, 0, 255);
    send_byte(8'h00, 0);
    chk("post_rst_row_done", 32'(row_done), 32'd1);
    chk("post_rst_csum_ok", 32'(csum_ok), 32'd1);
    chk("post_rst_row_addr_out", 32'(row_addr_out), 32'd1);
    @(posedge clk_in); #1;
    check_writes(4'h1, 8'h55, 256, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
